uart_frame_ctrl: RTL
====================

Name: uart_frame_ctrl

Overview:
- Sequences the byte stream from the UART receiver into 4-byte command frames and writes the decoded values into the VU meter's per-channel level registers and one config register.
- Sits between the UART receive block (`o_data`/`o_dv`) and the meter display logic.
- Handles frame sync, checksum check, inter-byte timeout and error counting.

Parameters:
- `N_CH`, 2, number of level channels (1..16).
- `SOF`, 8'hA5, start-of-frame byte.
- `CFG_ADDR`, 8'hFF, address of the config register.
- `TIMEOUT_CLKS`, 48000, max clocks between bytes inside a frame (1 ms at 48 MHz); width of the timeout counter is `$clog2(TIMEOUT_CLKS+1)`.

Ports:
- `i_clk`  input  1  system clock, 48 MHz.
- `i_rst`  input  1  asynchronous reset, active-high.
- `i_data`  input  8  received byte from the UART receiver.
- `i_dv`  input  1  receiver data-valid level flag; may stay high many cycles.
- `o_levels`  output  8*N_CH  level registers; channel k at bits [8k+7:8k].
- `o_cfg`  output  8  config register (gain/mode for display).
- `o_upd`  output  1  one-cycle pulse: a register was written.
- `o_upd_addr`  output  8  address written, valid while `o_upd`=1.
- `o_err_cnt`  output  8  saturating frame-error counter.
- `o_busy`  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- **Frame format:** SOF, ADDR, DATA, CHK, where CHK = ADDR ^ DATA.
- **Byte strobe:**
  - `dv_q` registers `i_dv`; byte strobe `stb` = `i_dv` & ~`dv_q`.
  - `i_data` is sampled on the `stb` cycle only.
  - A held-high `i_dv` yields exactly one byte.
- **Reset (async, `i_rst`=1):**
  - `o_levels`=0, `o_cfg`=0, `o_upd`=0, `o_upd_addr`=0, `o_err_cnt`=0, `o_busy`=0.
  - State=IDLE, timeout counter=0, addr/data latches=0.
  - `dv_q`=1, so a `i_dv` left high across reset is ignored.
  - Reset mid-frame discards the frame with no error counted.
- **States:**
  - IDLE: on `stb`, if `i_data`==SOF go to ADDR; any other byte is discarded silently (no error).
  - ADDR: on `stb`, latch addr, go to DATA. SOF value here is treated as an ordinary address (no resync).
  - DATA: on `stb`, latch data, go to CHK.
  - CHK: on `stb`, go to IDLE.
    - If `i_data`==addr^data and (addr<N_CH or addr==CFG_ADDR): write the register and pulse `o_upd` with `o_upd_addr`=addr.
    - Else: no write, `o_err_cnt`+1.
- **Write/`o_upd` latency:**
  - The register write and `o_upd` take effect at the clock edge that samples the CHK strobe.
  - `o_levels`/`o_cfg` show the new value and `o_upd`=1 in the following cycle.
  - `o_upd` is high for exactly one cycle, otherwise 0.
- **Timeout:**
  - In ADDR/DATA/CHK, the counter clears on each `stb` and on entry, else increments.
  - When the counter reaches TIMEOUT_CLKS-1 with no `stb`: go to IDLE, `o_err_cnt`+1, counter=0.
  - If `stb` and timeout occur in the same cycle, `stb` wins (byte processed, no error).
  - In IDLE the counter is held at 0.
- **Error counter:** saturates at 255; never wraps.
- **Simultaneous events:** `o_err_cnt` increments at most 1 per cycle; only one error source is possible per cycle.
- **Address range:** addr ≥ N_CH and ≠ CFG_ADDR is an error even when the checksum is good.
- **`o_busy`:** combinational from state (state != IDLE).

Test Plan:
- Reset with `i_dv` held high, then release → no frame activity, `o_busy`=0, all outputs 0; the first rising edge of `i_dv` is the first byte.
- Bytes A5,01,3C,3D (N_CH=2), each `i_dv` held 400 cycles → `o_levels`[15:8]=8'h3C, one `o_upd` pulse with `o_upd_addr`=01, `o_err_cnt`=0.
- Bytes A5,FF,07,F8 → `o_cfg`=8'h07, `o_upd_addr`=FF; then A5,00,55,00 (bad CHK) → `o_levels`[7:0] unchanged, `o_err_cnt`=1, no `o_upd`.
- Bytes A5,05,10,15 (bad addr, good CHK) → `o_err_cnt`+1, no write; leading garbage bytes 12,34 before A5 → no error counted.
- TIMEOUT_CLKS=100: A5,00 then 100 idle clocks → back in IDLE (`o_busy`=0), `o_err_cnt`+1; next complete frame is accepted normally.
- 300 consecutive bad-CHK frames → `o_err_cnt` stops at 8'hFF; assert `i_rst` during the DATA byte → immediate reset of all outputs, no `o_upd`.

Source files
------------

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl
// Groups UART receive bytes into 4-byte command frames (SOF, ADDR, DATA, CHK)
// and writes DATA into a per-channel level register or into the config register.
// CHK must equal ADDR ^ DATA. Bad checksums, out-of-range addresses and
// inter-byte timeouts each add one to a saturating error counter.
//
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous reset, active-high
//   i_data      received byte (sampled only on the rising edge of i_dv)
//   i_dv        receiver data-valid level flag
//   o_levels    level registers, channel k at [8k+7:8k]
//   o_cfg       config register
//   o_upd       one-cycle pulse after a register write
//   o_upd_addr  address of the last write, valid while o_upd=1
//   o_err_cnt   saturating frame-error counter
//   o_busy      high while a frame is in progress
module uart_frame_ctrl #(
  parameter int          N_CH         = 2,
  parameter logic [7:0]  SOF          = 8'hA5,
  parameter logic [7:0]  CFG_ADDR     = 8'hFF,
  parameter int          TIMEOUT_CLKS = 48000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [7:0]          i_data,
  input  logic                i_dv,
  output logic [8*N_CH-1:0]   o_levels,
  output logic [7:0]          o_cfg,
  output logic                o_upd,
  output logic [7:0]          o_upd_addr,
  output logic [7:0]          o_err_cnt,
  output logic                o_busy
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]        NCH_B    = 8'(N_CH);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CHK} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_dv_q;
  logic              w_stb;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [7:0]        r_addr, w_addr_nxt;
  logic [7:0]        r_data, w_data_nxt;
  logic              w_addr_ok;
  logic              w_wr;
  logic              w_err;
  logic [8*N_CH-1:0] r_levels;
  logic [7:0]        r_cfg;
  logic              r_upd;
  logic [7:0]        r_upd_addr;
  logic [7:0]        r_err_cnt;

  // One strobe per rising edge of i_dv; r_dv_q resets high so a level left
  // asserted across reset is not mistaken for a new byte.
  assign w_stb     = i_dv & ~r_dv_q;
  assign w_addr_ok = (r_addr < NCH_B) || (r_addr == CFG_ADDR);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_wr        = 1'b0;
    w_err       = 1'b0;
    if (r_state == S_IDLE) begin
      w_cnt_nxt = '0;
      if (w_stb && (i_data == SOF)) begin
        w_state_nxt = S_ADDR;
      end
    end else if (w_stb) begin
      // A byte arriving on the timeout cycle is still accepted.
      w_cnt_nxt = '0;
      case (r_state)
        S_ADDR: begin
          w_addr_nxt  = i_data;
          w_state_nxt = S_DATA;
        end
        S_DATA: begin
          w_data_nxt  = i_data;
          w_state_nxt = S_CHK;
        end
        default: begin
          w_state_nxt = S_IDLE;
          if ((i_data == (r_addr ^ r_data)) && w_addr_ok) begin
            w_wr = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      endcase
    end else if (r_cnt == CNT_LAST) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_err       = 1'b1;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_dv_q     <= 1'b1;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_levels   <= '0;
      r_cfg      <= '0;
      r_upd      <= 1'b0;
      r_upd_addr <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dv_q  <= i_dv;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_upd   <= w_wr;
      if (w_wr) begin
        r_upd_addr <= r_addr;
        if (r_addr == CFG_ADDR) begin
          r_cfg <= r_data;
        end else begin
          for (int k = 0; k < N_CH; k++) begin
            if (r_addr == 8'(k)) begin
              r_levels[8*k +: 8] <= r_data;
            end
          end
        end
      end
      if (w_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign o_levels   = r_levels;
  assign o_cfg      = r_cfg;
  assign o_upd      = r_upd;
  assign o_upd_addr = r_upd_addr;
  assign o_err_cnt  = r_err_cnt;
  assign o_busy     = (r_state != S_IDLE);

endmodule
